label_resolve_ctrl: RTL and testbench

//  Post-frame sequencer for the connected-components merge table and data table.
//  On start (end of frame, labeller stalled) it runs two passes:
//  - FLATTEN: rewrites every merge-table entry to its root label.
//  - EMIT: walks all labels; for each root, reads the data table and streams one

---
 rtl/label_resolve_ctrl.sv | 153 +++++++++++++++
 tb/tb_label_resolve_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/label_resolve_ctrl.sv
// label_resolve_ctrl
//   Post-frame sequencer for the connected-components merge table (M) and the
//   per-label data table. After an accepted start it flattens M so that every
//   entry holds its root label, then walks all labels and streams one object
//   record (label, area, sum_x, sum_y) per non-empty root over valid/ready.
//
// Ports
//   clk, reset_n        clock, synchronous active-low reset
//   start, num_labels   begin a run (IDLE only); labels 1..num_labels-1 exist
//   stall, busy, done   run status; done is a 1-cycle pulse at the end of a run
//   mt_*                merge-table read (1-cycle latency) and write ports
//   dt_raddr, dt_rdata  data-table read port (1-cycle latency)
//   obj_*               object record stream and count of records emitted
//   err_order           sticky flag: an entry M[i] > i was seen while flattening
module label_resolve_ctrl #(
    parameter int LABEL_W = 8,
    parameter int FEAT_W  = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LABEL_W-1:0]    num_labels,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [LABEL_W-1:0]    mt_raddr,
    input  logic [LABEL_W-1:0]    mt_rdata,
    output logic                  mt_wen,
    output logic [LABEL_W-1:0]    mt_waddr,
    output logic [LABEL_W-1:0]    mt_wdata,
    output logic [LABEL_W-1:0]    dt_raddr,
    input  logic [3*FEAT_W-1:0]   dt_rdata,
    output logic                  obj_valid,
    input  logic                  obj_ready,
    output logic [LABEL_W-1:0]    obj_label,
    output logic [FEAT_W-1:0]     obj_area,
    output logic [FEAT_W-1:0]     obj_sum_x,
    output logic [FEAT_W-1:0]     obj_sum_y,
    output logic [LABEL_W-1:0]    obj_count,
    output logic                  err_order
);

    typedef enum logic [3:0] {
        S_IDLE, S_F_RD, S_F_IND, S_F_WR,
        S_E_RD, S_E_CHK, S_E_DAT, S_E_OUT, S_E_NXT, S_DONE
    } state_t;

    localparam logic [LABEL_W-1:0] ONE = LABEL_W'(1);

    state_t             state, state_nx;
    logic [LABEL_W-1:0] idx;    // current label
    logic [LABEL_W-1:0] last;   // num_labels-1 captured at start

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // idx stops at last instead of incrementing, so it never wraps to 0
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx       <= '0;
            last      <= '0;
            err_order <= 1'b0;
            obj_count <= '0;
            obj_label <= '0;
            obj_area  <= '0;
            obj_sum_x <= '0;
            obj_sum_y <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    idx       <= ONE;
                    last      <= num_labels - ONE;
                    err_order <= 1'b0;
                    obj_count <= '0;
                end
                S_F_IND: if (mt_rdata > idx) err_order <= 1'b1;
                S_F_WR:  idx <= (idx == last) ? ONE : idx + ONE;
                S_E_DAT: begin
                    obj_label <= idx;
                    obj_area  <= dt_rdata[FEAT_W-1:0];
                    obj_sum_y <= dt_rdata[2*FEAT_W-1:FEAT_W];
                    obj_sum_x <= dt_rdata[3*FEAT_W-1:2*FEAT_W];
                end
                S_E_OUT: if (obj_ready) obj_count <= obj_count + ONE;
                S_E_NXT: if (idx != last) idx <= idx + ONE;
                default: ;
            endcase
        end
    end

    // All combinational outputs are forced to 0 while reset_n is low, so no
    // table write escapes in the reset cycle even if the FSM sits in F_WR.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        obj_valid = 1'b0;
        mt_raddr  = '0;
        mt_wen    = 1'b0;
        mt_waddr  = '0;
        mt_wdata  = '0;
        dt_raddr  = '0;
        if (reset_n) begin
            busy = (state != S_IDLE) && (state != S_DONE);
            case (state)
                S_IDLE: if (start) state_nx = (num_labels <= ONE) ? S_DONE : S_F_RD;
                S_F_RD: begin
                    mt_raddr = idx;
                    state_nx = S_F_IND;
                end
                // M[i] <= i guarantees M[M[i]] was already flattened to a root
                S_F_IND: begin
                    mt_raddr = mt_rdata;
                    state_nx = S_F_WR;
                end
                S_F_WR: begin
                    mt_wen   = 1'b1;
                    mt_waddr = idx;
                    mt_wdata = mt_rdata;
                    state_nx = (idx == last) ? S_E_RD : S_F_RD;
                end
                S_E_RD: begin
                    mt_raddr = idx;
                    state_nx = S_E_CHK;
                end
                S_E_CHK: begin
                    if (mt_rdata == idx) begin
                        dt_raddr = idx;
                        state_nx = S_E_DAT;
                    end else begin
                        state_nx = S_E_NXT;
                    end
                end
                S_E_DAT: state_nx = (dt_rdata[FEAT_W-1:0] == '0) ? S_E_NXT : S_E_OUT;
                S_E_OUT: begin
                    obj_valid = 1'b1;
                    if (obj_ready) state_nx = S_E_NXT;
                end
                S_E_NXT: state_nx = (idx == last) ? S_DONE : S_E_RD;
                S_DONE: begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    assign stall = busy;

endmodule

// File: tb/tb_label_resolve_ctrl.sv
module tb_label_resolve_ctrl;

    localparam int LW = 8;
    localparam int FW = 128;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [LW-1:0]   num_labels = '0;
    logic            stall, busy, done;
    logic [LW-1:0]   mt_raddr, mt_rdata, mt_waddr, mt_wdata, dt_raddr;
    logic            mt_wen;
    logic [3*FW-1:0] dt_rdata;
    logic            obj_valid;
    logic            obj_ready;
    logic [LW-1:0]   obj_label, obj_count;
    logic [FW-1:0]   obj_area, obj_sum_x, obj_sum_y;
    logic            err_order;

    always #5 clk = ~clk;

    label_resolve_ctrl #(.LABEL_W(LW), .FEAT_W(FW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .num_labels(num_labels),
        .stall(stall), .busy(busy), .done(done),
        .mt_raddr(mt_raddr), .mt_rdata(mt_rdata), .mt_wen(mt_wen),
        .mt_waddr(mt_waddr), .mt_wdata(mt_wdata),
        .dt_raddr(dt_raddr), .dt_rdata(dt_rdata),
        .obj_valid(obj_valid), .obj_ready(obj_ready), .obj_label(obj_label),
        .obj_area(obj_area), .obj_sum_x(obj_sum_x), .obj_sum_y(obj_sum_y),
        .obj_count(obj_count), .err_order(err_order)
    );

    // table models with 1-cycle read latency and a bench load port
    logic [LW-1:0]   mt_mem [0:255];
    logic [3*FW-1:0] dt_mem [0:255];
    logic            ld_en = 1'b0;
    logic [LW-1:0]   ld_addr = '0, ld_m = '0;
    logic [3*FW-1:0] ld_d = '0;

    always @(posedge clk) begin
        if (ld_en) begin
            mt_mem[ld_addr] <= ld_m;
            dt_mem[ld_addr] <= ld_d;
        end else if (mt_wen) begin
            mt_mem[mt_waddr] <= mt_wdata;
        end
        mt_rdata <= mt_mem[mt_raddr];
        dt_rdata <= dt_mem[dt_raddr];
    end

    logic ready_en = 1'b1;
    assign obj_ready = ready_en;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [LW-1:0] lbl;
        logic [FW-1:0] area, sx, sy;
    } rec_t;
    rec_t sb[$];

    int m_init [0:15];
    int a_init [0:15];
    int exp_cnt;
    int done_cnt = 0;
    int wen_cnt = 0;

    function automatic logic [FW-1:0] sx_of(int l);
        return FW'(a_init[l] * 16 + l);
    endfunction
    function automatic logic [FW-1:0] sy_of(int l);
        return FW'(a_init[l] * 2 + 3 * l);
    endfunction

    function automatic int walk_root(int l);
        int r = l;
        for (int k = 0; k < 16; k++) if (m_init[r] != r) r = m_init[r];
        return r;
    endfunction

    // pattern 0: M={1:1,2:1,3:2,4:4}, areas {5,3,2,7}
    // pattern 1: M={1:1,2:1,3:5,4:4,5:5}, areas {2,4,6,0,9}
    task automatic setup(input int pat);
        for (int l = 0; l < 16; l++) begin
            m_init[l] = l;
            a_init[l] = 0;
        end
        if (pat == 0) begin
            m_init[2] = 1; m_init[3] = 2;
            a_init[1] = 5; a_init[2] = 3; a_init[3] = 2; a_init[4] = 7;
        end else begin
            m_init[2] = 1; m_init[3] = 5;
            a_init[1] = 2; a_init[2] = 4; a_init[3] = 6; a_init[4] = 0; a_init[5] = 9;
        end
        for (int l = 0; l < 16; l++) begin
            @(negedge clk);
            ld_en = 1'b1;
            ld_addr = LW'(l);
            ld_m = LW'(m_init[l]);
            ld_d = {sx_of(l), sy_of(l), FW'(a_init[l])};
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_exp(input int n);
        rec_t r;
        exp_cnt = 0;
        for (int l = 1; l < n; l++) begin
            if (m_init[l] == l && a_init[l] != 0) begin
                r.lbl = LW'(l); r.area = FW'(a_init[l]); r.sx = sx_of(l); r.sy = sy_of(l);
                sb.push_back(r);
                exp_cnt++;
            end
        end
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        num_labels = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, seen, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    // record monitor: pops the scoreboard on each handshake, checks hold-while-stalled
    logic          prev_wait = 1'b0;
    logic [LW-1:0] prev_lbl;
    logic [FW-1:0] prev_area;

    always @(negedge clk) begin
        rec_t e;
        if (done) done_cnt++;
        if (mt_wen) wen_cnt++;
        if (reset_n && prev_wait) begin
            check("valid_held", obj_valid, 1'b1);
            check("label_held", obj_label, prev_lbl);
            check("area_held", obj_area, prev_area);
        end
        if (reset_n && obj_valid && obj_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_record", obj_label, 0);
            end else begin
                e = sb.pop_front();
                check("rec_label", obj_label, e.lbl);
                check("rec_area", obj_area, e.area);
                check("rec_sum_x", obj_sum_x, e.sx);
                check("rec_sum_y", obj_sum_y, e.sy);
            end
        end
        prev_wait = reset_n && obj_valid && !obj_ready;
        prev_lbl  = obj_label;
        prev_area = obj_area;
    end

    initial begin
        bit found;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", obj_valid, 0);
        check("rst_wen", mt_wen, 0);
        check("rst_count", obj_count, 0);
        check("rst_err", err_order, 0);
        reset_n = 1'b1;
        setup(0);

        // 1: single label -> done two cycles after start is raised, no writes
        wen_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1; num_labels = 8'd1;
        @(negedge clk);
        check("t1_done_early", done, 0);
        @(negedge clk);
        check("t1_done_lat2", done, 1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t1_done_once", done_cnt, 1);
        check("t1_no_wen", wen_cnt, 0);
        check("t1_count", obj_count, 0);

        // 2: flatten + emit, ready held high
        setup(0);
        push_exp(5);
        wen_cnt = 0; done_cnt = 0;
        pulse_start(5);
        wait_done("t2_done");
        for (int l = 1; l < 5; l++) check("t2_flat", mt_mem[l], walk_root(l));
        check("t2_count", obj_count, exp_cnt);
        check("t2_sb_empty", sb.size(), 0);
        check("t2_wen", wen_cnt, 4);
        check("t2_done_once", done_cnt, 1);
        check("t2_err", err_order, 0);

        // 3: valid before ready, 10 stalled cycles, start during busy ignored
        setup(0);
        push_exp(5);
        done_cnt = 0;
        @(posedge clk); #1;
        ready_en = 1'b0;
        pulse_start(5);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (obj_valid) found = 1'b1;
        end
        check("t3_valid_seen", found, 1);
        pulse_start(2);
        repeat (8) @(negedge clk);
        check("t3_still_busy", busy, 1);
        @(posedge clk); #1;
        ready_en = 1'b1;
        wait_done("t3_done");
        check("t3_count", obj_count, exp_cnt);
        check("t3_sb_empty", sb.size(), 0);
        check("t3_done_once", done_cnt, 1);

        // 4/6: M[3]=5 violates ordering; root 4 has area 0 and is skipped
        setup(1);
        push_exp(6);
        done_cnt = 0;
        pulse_start(6);
        wait_done("t4_done");
        check("t4_err", err_order, 1);
        check("t4_count", obj_count, exp_cnt);
        check("t4_sb_empty", sb.size(), 0);
        check("t4_done_once", done_cnt, 1);

        // 5: reset during FLATTEN in the F_WR cycle of label 2
        setup(0);
        pulse_start(5);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (mt_wen && mt_waddr == 8'd1) found = 1'b1;
        end
        check("t5_reach_i1", found, 1);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("t5_no_write", mt_wen, 0);
        @(negedge clk);
        check("t5_busy", busy, 0);
        check("t5_valid", obj_valid, 0);
        check("t5_count", obj_count, 0);
        check("t5_err", err_order, 0);
        reset_n = 1'b1;
        sb.delete();
        setup(0);
        push_exp(5);
        done_cnt = 0;
        pulse_start(5);
        wait_done("t5_rerun_done");
        check("t5_rerun_count", obj_count, exp_cnt);
        check("t5_rerun_sb", sb.size(), 0);
        check("t5_rerun_flat3", mt_mem[3], walk_root(3));
        check("t5_done_once", done_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
